genius_input_capture: RTL

- Player-side counterpart of the sequence display path: samples the four raw colour buttons and synchronises, debounces and validates them.
- Encodes each accepted press into the 2-bit colour code used by the stored sequence, then hands it to the game FSM over a valid/ready handshake.
- Active only while the game FSM holds it enabled (GET_PLAYER_INPUT); reports a player timeout.

---
 rtl/genius_input_capture_if.sv | 21 ++
 rtl/genius_input_capture.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/genius_input_capture_if.sv
// Colour hand-off from the input capture block to the game comparison logic.
// The master drives the code and its valid flag; the slave returns ready.
interface genius_input_capture_if #(
  parameter int DATA_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] color_o;
  logic                  color_valid_o;
  logic                  color_ready_i;

  modport master (
    output color_o,
    output color_valid_o,
    input  color_ready_i
  );

  modport slave (
    input  color_o,
    input  color_valid_o,
    output color_ready_i
  );
endinterface

// File: rtl/genius_input_capture.sv
// Player button capture: synchronises, debounces and validates the four colour
// buttons, then offers each accepted press once as a colour code.
module genius_input_capture #(
  parameter int DATA_WIDTH      = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic [3:0]             btn_i,
  genius_input_capture_if.master cap_if,
  output logic                   timeout_o,
  output logic                   busy_o
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ARM          = 3'd1,
    S_WAIT_PRESS   = 3'd2,
    S_DEB_PRESS    = 3'd3,
    S_PRESENT      = 3'd4,
    S_WAIT_RELEASE = 3'd5,
    S_TIMED_OUT    = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_sync1;
  logic [3:0]            r_btn_s;
  logic [DEB_W-1:0]      r_deb_cnt;
  logic [DEB_W-1:0]      w_deb_cnt_next;
  logic [TO_W-1:0]       r_to_cnt;
  logic [TO_W-1:0]       w_to_cnt_next;
  logic [1:0]            r_code;
  logic [1:0]            w_code_next;
  logic [DATA_WIDTH-1:0] r_color;
  logic [DATA_WIDTH-1:0] w_color_next;

  logic [3:0] w_is_btn;
  logic       w_onehot;
  logic       w_btn_zero;
  logic       w_match;
  logic [1:0] w_code_enc;

  // Exact one-hot match per colour; zero and multi-hot patterns match none.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_colour
      assign w_is_btn[gi] = (r_btn_s == 4'(1 << gi));
    end
  endgenerate

  assign w_onehot   = |w_is_btn;
  assign w_btn_zero = (r_btn_s == 4'b0000);
  assign w_match    = w_is_btn[r_code];
  assign w_code_enc = {w_is_btn[3] | w_is_btn[2], w_is_btn[3] | w_is_btn[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 4'b0000;
      r_btn_s   <= 4'b0000;
      r_state   <= S_IDLE;
      r_deb_cnt <= '0;
      r_to_cnt  <= '0;
      r_code    <= 2'd0;
      r_color   <= '0;
    end else begin
      r_sync1   <= btn_i;
      r_btn_s   <= r_sync1;
      r_state   <= w_state_next;
      r_deb_cnt <= w_deb_cnt_next;
      r_to_cnt  <= w_to_cnt_next;
      r_code    <= w_code_next;
      r_color   <= w_color_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_deb_cnt_next = r_deb_cnt;
    w_to_cnt_next  = r_to_cnt;
    w_code_next    = r_code;
    w_color_next   = r_color;
    if (!enable_i) begin
      w_state_next   = S_IDLE;
      w_deb_cnt_next = '0;
      w_to_cnt_next  = '0;
      w_code_next    = 2'd0;
      w_color_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next   = S_ARM;
          w_deb_cnt_next = '0;
          w_to_cnt_next  = '0;
        end
        // Both quiet phases demand a fully released pad before the next press.
        S_ARM, S_WAIT_RELEASE: begin
          if (!w_btn_zero) begin
            w_deb_cnt_next = '0;
          end else if (r_deb_cnt == DEB_LAST) begin
            w_state_next   = S_WAIT_PRESS;
            w_deb_cnt_next = '0;
            w_to_cnt_next  = '0;
          end else begin
            w_deb_cnt_next = r_deb_cnt + 1'b1;
          end
        end
        S_WAIT_PRESS: begin
          if (r_to_cnt == TO_LAST) begin
            w_state_next = S_TIMED_OUT;
          end else begin
            w_to_cnt_next = r_to_cnt + 1'b1;
            if (w_onehot) begin
              w_state_next   = S_DEB_PRESS;
              w_code_next    = w_code_enc;
              w_deb_cnt_next = '0;
            end
          end
        end
        // Debounce completion takes priority over a simultaneous timeout.
        S_DEB_PRESS: begin
          if (w_match && r_deb_cnt == DEB_LAST) begin
            w_state_next   = S_PRESENT;
            w_color_next   = DATA_WIDTH'(r_code);
            w_deb_cnt_next = '0;
          end else if (r_to_cnt == TO_LAST) begin
            w_state_next = S_TIMED_OUT;
          end else begin
            w_to_cnt_next = r_to_cnt + 1'b1;
            if (w_match) begin
              w_deb_cnt_next = r_deb_cnt + 1'b1;
            end else begin
              w_state_next   = S_WAIT_PRESS;
              w_deb_cnt_next = '0;
            end
          end
        end
        S_PRESENT: begin
          if (cap_if.color_ready_i) begin
            w_state_next   = S_WAIT_RELEASE;
            w_deb_cnt_next = '0;
          end
        end
        S_TIMED_OUT: begin
          w_state_next = S_TIMED_OUT;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cap_if.color_o       = r_color;
    cap_if.color_valid_o = (r_state == S_PRESENT);
    timeout_o            = (r_state == S_TIMED_OUT);
    busy_o               = (r_state != S_IDLE);
  end

endmodule
